// File: rtl/spi_edge_shift_if.sv
// Bundle between the edge FSM/test side and the SPI shift stage.
// Latency: none (wires only).
// Backpressure: none; the FSM paces frames with Reg_Rst and watches EdgDone.
// Ports (slave view): Reg_Rst/AMP_ADC/SPI_CLK/gain/MISO in; EdgDone/MOSI/AMP_CS,
// adc_ch0/adc_ch1/data_valid out.
interface spi_edge_shift_if #(
    parameter int ADC_BITS = 14
);
    logic                Reg_Rst;
    logic                AMP_ADC;
    logic                SPI_CLK;
    logic [7:0]          gain;
    logic                MISO;
    logic                EdgDone;
    logic                MOSI;
    logic                AMP_CS;
    logic [ADC_BITS-1:0] adc_ch0;
    logic [ADC_BITS-1:0] adc_ch1;
    logic                data_valid;

    modport master (
        output Reg_Rst, AMP_ADC, SPI_CLK, gain, MISO,
        input  EdgDone, MOSI, AMP_CS, adc_ch0, adc_ch1, data_valid
    );

    modport slave (
        input  Reg_Rst, AMP_ADC, SPI_CLK, gain, MISO,
        output EdgDone, MOSI, AMP_CS, adc_ch0, adc_ch1, data_valid
    );
endinterface

// File: rtl/spi_edge_shift.sv
// SPI datapath for the edge FSM: shifts an 8-bit amp gain out, or reads a 2x14-bit ADC frame.
// Latency: SPI_CLK edges act 1 clk after they occur; EdgDone/data_valid assert in the clk the last rise is processed.
// Backpressure: none; Reg_Rst (re)starts a frame at any time, EdgDone holds until the next Reg_Rst.
// Ports: clk, rst (async active-low), bus (slave modport of spi_edge_shift_if).
module spi_edge_shift #(
    parameter int AMP_BITS  = 8,
    parameter int ADC_FRAME = 34,
    parameter int ADC_BITS  = 14
) (
    input  logic             clk,
    input  logic             rst,
    spi_edge_shift_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [5:0] AMP_END   = 6'(AMP_BITS);
    localparam logic [5:0] FRAME_END = 6'(ADC_FRAME);
    // Rise numbers that complete each channel sample (MSB-first).
    localparam logic [5:0] CH0_K     = 6'(2 + ADC_BITS);
    localparam logic [5:0] CH1_K     = 6'(4 + 2 * ADC_BITS);

    state_t              state, state_nxt;
    logic                sclk_q;
    logic                rise, fall;
    logic                mode;
    logic [5:0]          cnt, cnt_inc;
    logic [7:0]          tx_sr;
    logic [ADC_BITS-1:0] rx_sr, rx_nxt;
    logic [ADC_BITS-1:0] ch0_hold, ch1_hold;
    logic [ADC_BITS-1:0] ch0_q, ch1_q;
    logic                edg_done_q, cs_q, dv_q;
    logic                start, do_rise, do_fall, frame_end;

    assign rise    = bus.SPI_CLK & ~sclk_q;
    assign fall    = ~bus.SPI_CLK & sclk_q;
    assign start   = bus.Reg_Rst;
    // Counter saturates at the ADC frame length rather than wrapping.
    assign cnt_inc = (cnt == FRAME_END) ? cnt : cnt + 6'd1;
    assign rx_nxt  = {rx_sr[ADC_BITS-2:0], bus.MISO};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; Reg_Rst overrides everything, including a coincident edge.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = SHIFT;
        end else if (state == SHIFT && rise &&
                     cnt_inc == (mode ? AMP_END : FRAME_END)) begin
            state_nxt = DONE;
        end
    end

    // Control strobes for the datapath.
    always_comb begin
        do_rise   = 1'b0;
        do_fall   = 1'b0;
        frame_end = 1'b0;
        if (!start && state == SHIFT) begin
            do_rise   = rise;
            // A fall ahead of the first rise would lose gain[7] before it is sampled.
            do_fall   = fall && mode && (cnt != 6'd0);
            frame_end = rise && (state_nxt == DONE);
        end
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_q     <= 1'b0;
            mode       <= 1'b1;
            cnt        <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            ch0_hold   <= '0;
            ch1_hold   <= '0;
            ch0_q      <= '0;
            ch1_q      <= '0;
            edg_done_q <= 1'b0;
            cs_q       <= 1'b1;
            dv_q       <= 1'b0;
        end else begin
            sclk_q <= bus.SPI_CLK;
            dv_q   <= 1'b0;
            if (start) begin
                cnt        <= '0;
                mode       <= bus.AMP_ADC;
                edg_done_q <= 1'b0;
                rx_sr      <= '0;
                if (bus.AMP_ADC) begin
                    tx_sr <= bus.gain;
                    cs_q  <= 1'b0;
                end else begin
                    tx_sr <= '0;
                    cs_q  <= 1'b1;
                end
            end else begin
                if (do_rise) begin
                    cnt <= cnt_inc;
                    if (!mode) begin
                        rx_sr <= rx_nxt;
                        if (cnt_inc == CH0_K) ch0_hold <= rx_nxt;
                        if (cnt_inc == CH1_K) ch1_hold <= rx_nxt;
                    end
                end
                if (do_fall) begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
                if (frame_end) begin
                    edg_done_q <= 1'b1;
                    if (mode) begin
                        cs_q <= 1'b1;
                    end else begin
                        // Bypass the holding registers if a channel ends on the last rise.
                        ch0_q <= (CH0_K == FRAME_END) ? rx_nxt : ch0_hold;
                        ch1_q <= (CH1_K == FRAME_END) ? rx_nxt : ch1_hold;
                        dv_q  <= 1'b1;
                    end
                end
            end
        end
    end

    // MOSI is the live MSB of tx_sr; tx_sr is zero in ADC mode and after reset.
    assign bus.MOSI       = tx_sr[7];
    assign bus.AMP_CS     = cs_q;
    assign bus.EdgDone    = edg_done_q;
    assign bus.adc_ch0    = ch0_q;
    assign bus.adc_ch1    = ch1_q;
    assign bus.data_valid = dv_q;
endmodule

// File: tb/tb_spi_edge_shift.sv
module tb_spi_edge_shift;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_edge_shift_if bus ();
    spi_edge_shift dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [27:0] exp_q[$];
    logic [27:0] exp_word;
    logic        prev_dv  = 1'b0;
    logic        prev_edg = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Scoreboard consumer: every data_valid pulse must match a queued frame.
    always @(negedge clk) begin
        if (bus.data_valid) begin
            check("dv_width", 32'(prev_dv), 0);
            check("dv_with_edgdone_rise", {prev_edg, bus.EdgDone}, 2'b01);
            if (exp_q.size() == 0) begin
                check("dv_unexpected", 32'(bus.data_valid), 0);
            end else begin
                exp_word = exp_q.pop_front();
                check("adc_data", {bus.adc_ch0, bus.adc_ch1}, exp_word);
            end
        end
        prev_dv  = bus.data_valid;
        prev_edg = bus.EdgDone;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reg_rst();
        bus.Reg_Rst = 1'b1;
        tick(1);
        bus.Reg_Rst = 1'b0;
    endtask

    task automatic spi_cycle(input logic miso);
        bus.MISO    = miso;
        bus.SPI_CLK = 1'b1;
        tick(4);
        bus.SPI_CLK = 1'b0;
        tick(4);
    endtask

    function automatic logic adc_bit(input int k, input logic [13:0] c0, input logic [13:0] c1);
        if (k >= 3 && k <= 16)  return c0[16-k];
        if (k >= 19 && k <= 32) return c1[32-k];
        return 1'($urandom_range(0, 1));
    endfunction

    // Eight amp bits; frame must already be started with gain g.
    task automatic amp_bits(input logic [7:0] g);
        for (int i = 0; i < 8; i++) begin
            check("amp_mosi", 32'(bus.MOSI), 32'(g[7-i]));
            bus.SPI_CLK = 1'b1;
            tick(1);
            if (i == 7) begin
                check("amp_done_edg", 32'(bus.EdgDone), 1);
                check("amp_done_cs", 32'(bus.AMP_CS), 1);
            end else begin
                check("amp_mid_cs", 32'(bus.AMP_CS), 0);
                check("amp_mid_edg", 32'(bus.EdgDone), 0);
            end
            tick(3);
            bus.SPI_CLK = 1'b0;
            tick(4);
        end
    endtask

    task automatic amp_frame(input logic [7:0] g);
        bus.AMP_ADC = 1'b1;
        bus.gain    = g;
        pulse_reg_rst();
        check("amp_start_cs", 32'(bus.AMP_CS), 0);
        check("amp_start_edg", 32'(bus.EdgDone), 0);
        amp_bits(g);
    endtask

    task automatic adc_frame(input logic [13:0] c0, input logic [13:0] c1, input int nrise);
        bus.AMP_ADC = 1'b0;
        pulse_reg_rst();
        bus.AMP_ADC = 1'b1;   // mode is latched at Reg_Rst only
        check("adc_start_edg", 32'(bus.EdgDone), 0);
        if (nrise == 34) exp_q.push_back({c0, c1});
        for (int k = 1; k <= nrise; k++) spi_cycle(adc_bit(k, c0, c1));
        check("adc_cs_high", 32'(bus.AMP_CS), 1);
    endtask

    initial begin
        rst         = 1'b0;
        bus.Reg_Rst = 1'b0;
        bus.AMP_ADC = 1'b0;
        bus.SPI_CLK = 1'b0;
        bus.gain    = 8'h00;
        bus.MISO    = 1'b0;

        // Reset held while inputs toggle.
        tick(2);
        for (int i = 0; i < 3; i++) begin
            bus.AMP_ADC = 1'b1;
            bus.gain    = 8'hFF;
            bus.SPI_CLK = 1'b1;
            bus.Reg_Rst = 1'b1;
            tick(2);
            bus.SPI_CLK = 1'b0;
            bus.Reg_Rst = 1'b0;
            tick(2);
        end
        check("rst_edg", 32'(bus.EdgDone), 0);
        check("rst_cs", 32'(bus.AMP_CS), 1);
        check("rst_mosi", 32'(bus.MOSI), 0);
        check("rst_ch0", 32'(bus.adc_ch0), 0);
        check("rst_ch1", 32'(bus.adc_ch1), 0);
        check("rst_dv", 32'(bus.data_valid), 0);

        // Released, but no Reg_Rst: edges must be ignored in IDLE.
        rst = 1'b1;
        for (int i = 0; i < 40; i++) spi_cycle(1'b1);
        check("idle_edg", 32'(bus.EdgDone), 0);
        check("idle_cs", 32'(bus.AMP_CS), 1);

        // Amp load of 0xA5.
        amp_frame(8'hA5);
        spi_cycle(1'b0);
        check("amp_hold_edg", 32'(bus.EdgDone), 1);
        check("amp_hold_cs", 32'(bus.AMP_CS), 1);

        // Full ADC frame, then extra clocks that must change nothing.
        adc_frame(14'h2AAB, 14'h1234, 34);
        check("adc1_ch0", 32'(bus.adc_ch0), 32'h2AAB);
        check("adc1_ch1", 32'(bus.adc_ch1), 32'h1234);
        check("adc1_sb_drained", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) spi_cycle(1'b1);
        check("adc1_frozen_ch0", 32'(bus.adc_ch0), 32'h2AAB);
        check("adc1_frozen_ch1", 32'(bus.adc_ch1), 32'h1234);
        check("adc1_frozen_edg", 32'(bus.EdgDone), 1);

        // Mid-frame abort after 20 rises, then a clean frame.
        adc_frame(14'h3FFF, 14'h0000, 20);
        check("abort_no_edg", 32'(bus.EdgDone), 0);
        check("abort_ch0_kept", 32'(bus.adc_ch0), 32'h2AAB);
        adc_frame(14'h0001, 14'h3FFF, 34);
        check("adc2_ch0", 32'(bus.adc_ch0), 32'h0001);
        check("adc2_ch1", 32'(bus.adc_ch1), 32'h3FFF);

        // Collision: Reg_Rst in the same clk as a processed rise.
        bus.AMP_ADC = 1'b1;
        bus.gain    = 8'hF0;
        pulse_reg_rst();
        for (int i = 0; i < 3; i++) spi_cycle(1'b0);
        bus.gain    = 8'h3C;
        bus.SPI_CLK = 1'b1;
        bus.Reg_Rst = 1'b1;
        tick(1);
        bus.Reg_Rst = 1'b0;
        check("coll_mosi", 32'(bus.MOSI), 0);
        check("coll_cs", 32'(bus.AMP_CS), 0);
        tick(3);
        bus.SPI_CLK = 1'b0;
        tick(4);
        check("coll_fall_ignored_mosi", 32'(bus.MOSI), 0);
        amp_bits(8'h3C);

        // Asynchronous reset in the middle of an amp frame.
        amp_frame_start_async();

        tick(4);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    task automatic amp_frame_start_async();
        bus.AMP_ADC = 1'b1;
        bus.gain    = 8'hFF;
        pulse_reg_rst();
        for (int i = 0; i < 5; i++) spi_cycle(1'b0);
        check("async_pre_cs", 32'(bus.AMP_CS), 0);
        check("async_pre_mosi", 32'(bus.MOSI), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_cs", 32'(bus.AMP_CS), 1);
        check("async_edg", 32'(bus.EdgDone), 0);
        check("async_mosi", 32'(bus.MOSI), 0);
        check("async_ch0", 32'(bus.adc_ch0), 0);
        check("async_ch1", 32'(bus.adc_ch1), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask
endmodule

// File: doc/spi_edge_shift.md
Name: spi_edge_shift

Overview:
- SPI datapath stage paired with the edge FSM (FSMFLancos), on the SPI side of that FSM.
- Consumes the FSM's SPI_CLK, AMP_ADC and Reg_Rst; returns EdgDone.
- In amplifier mode, shifts an 8-bit gain word out MSB-first on MOSI with AMP_CS framing.
- In ADC mode, counts a 34-clock LTC1407A-style frame and deserialises two 14-bit channel samples from MISO.

Parameters:
- AMP_BITS, 8: SPI_CLK rising edges per amplifier frame.
- ADC_FRAME, 34: SPI_CLK rising edges per ADC frame (legal range 1..63).
- ADC_BITS, 14: bits per ADC channel sample.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- Reg_Rst  in  1  from FSM; synchronous frame start/clear, active high.
- AMP_ADC  in  1  from FSM; mode select (1 = amplifier load, 0 = ADC read); sampled only at Reg_Rst.
- SPI_CLK  in  1  from FSM; serial clock level, synchronous to clk, high and low phases each ≥1 clk.
- gain  in  8  amplifier gain word, sampled at Reg_Rst.
- MISO  in  1  ADC serial data.
- EdgDone  out  1  to FSM; frame complete, held high until the next Reg_Rst.
- MOSI  out  1  amplifier serial data.
- AMP_CS  out  1  amplifier chip select, active low.
- adc_ch0  out  14  last completed channel-0 sample.
- adc_ch1  out  14  last completed channel-1 sample.
- data_valid  out  1  one-clk pulse when adc_ch0/adc_ch1 update.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - EdgDone=0, MOSI=0, AMP_CS=1, data_valid=0.
  - adc_ch0=0, adc_ch1=0.
  - edge counter=0, shift registers=0, sclk_q=0, mode=1, state=IDLE.
- Edge detection:
  - sclk_q registers SPI_CLK every clk.
  - rise = SPI_CLK & ~sclk_q; fall = ~SPI_CLK & sclk_q.
  - Edges are acted on in the clk cycle after SPI_CLK changes (1-clk latency).
- State IDLE:
  - All edges ignored.
  - Reg_Rst -> SHIFT, with the following loads:
    - counter=0, mode<=AMP_ADC, EdgDone<=0.
    - amp mode: tx_sr<=gain, MOSI<=gain[7], AMP_CS<=0.
    - ADC mode: rx_sr<=0, AMP_CS stays 1, MOSI=0.
- State SHIFT, on each rise:
  - counter increments.
  - ADC mode also shifts MISO into rx_sr LSB.
- State SHIFT, on each fall (amp mode only):
  - tx_sr shifts left one bit; MOSI<=new tx_sr[7].
  - A fall before the first rise is ignored.
- Amp frame end:
  - When the rise that makes counter==AMP_BITS is processed: -> DONE, EdgDone<=1, AMP_CS<=1 in that same clk.
- ADC frame bit numbering: rise k=1..ADC_FRAME.
  - Bits 3..(2+ADC_BITS), i.e. 3..16, form ch0, MSB first.
  - Bits (5+ADC_BITS)..(4+2*ADC_BITS), i.e. 19..32, form ch1, MSB first.
  - All other bits are don't-care and are not stored.
  - Capture: rx_sr is copied to a ch0 holding register at k=16; ch1 is taken from rx_sr at k=32.
- ADC frame end:
  - When the rise with counter==ADC_FRAME is processed: -> DONE, EdgDone<=1, adc_ch0/adc_ch1 updated, data_valid=1 for exactly that clk.
- State DONE:
  - Edges ignored; EdgDone held at 1; outputs frozen.
  - Reg_Rst -> SHIFT, with the same loads as from IDLE.
- Reg_Rst in SHIFT (mid-frame abort):
  - Restarts the frame with the IDLE loads.
  - adc_ch0/adc_ch1 are not updated; no data_valid.
- Simultaneous events:
  - Reg_Rst together with rise/fall in the same clk: Reg_Rst wins and the edge is discarded.
  - AMP_ADC changing mid-frame has no effect.
- Counter: 6 bits; it saturates at ADC_FRAME and never wraps.
- Partial frames never alter adc_ch0/adc_ch1.

Test Plan:
- Reset check: hold rst=0 while toggling SPI_CLK and pulsing Reg_Rst -> EdgDone=0, AMP_CS=1, MOSI=0, adc_ch0=adc_ch1=0, data_valid=0. Release rst without Reg_Rst and toggle 40 SPI_CLK cycles -> EdgDone stays 0.
- Amp load: AMP_ADC=1, gain=8'hA5, Reg_Rst pulse, 8 SPI_CLK cycles (4 clk high / 4 clk low).
  - MOSI sampled at each SPI_CLK rise reads 1,0,1,0,0,1,0,1.
  - AMP_CS=0 from 1 clk after Reg_Rst until the 8th rise is processed, then 1.
  - EdgDone rises in that same clk and holds.
- ADC read: AMP_ADC=0, Reg_Rst, 34 cycles. MISO drives 2 zeros, 14'h2AAB, 2 zeros, 14'h1234, 2 zeros.
  - adc_ch0=14'h2AAB, adc_ch1=14'h1234.
  - data_valid high for exactly 1 clk, coincident with EdgDone rising.
  - Extra SPI_CLK cycles afterwards change nothing.
- Mid-frame abort: start an ADC frame, assert Reg_Rst after 20 rises, then run a full 34-cycle frame with ch0=14'h0001, ch1=14'h3FFF.
  - No data_valid pulse and no EdgDone during the aborted frame.
  - Final adc_ch0=14'h0001, adc_ch1=14'h3FFF.
- Collision: assert Reg_Rst in the same clk as a processed rise -> counter=0 afterwards and the edge is lost. A subsequent full amp frame still needs 8 rises for EdgDone.
- Async reset mid-frame: drop rst after 5 amp rises -> AMP_CS=1 and EdgDone=0 immediately, without waiting for a clk edge.
